// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: shared core widths and register-address type.
// Imported by the register file, operand fetch and execute stages.
package kgp_risc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 16;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// reg_scoreboard: one busy bit per register, marking a pending writeback.
// Two source checks plus a destination (WAW) check, all combinational.
module reg_scoreboard
  import kgp_risc_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          setEn,
  input  logic [AW-1:0] setAddr,
  input  logic          clrEn,
  input  logic [AW-1:0] clrAddr,
  input  logic [AW-1:0] chkA,
  input  logic [AW-1:0] chkB,
  input  logic [AW-1:0] chkW,
  output logic          busyA,
  output logic          busyB,
  output logic          busyW
);

  logic [2**AW-1:0] busy;

  // Writeback clears first, issue sets last: a same-cycle set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clrEn) busy[clrAddr] <= 1'b0;
      if (setEn) busy[setAddr] <= 1'b1;
    end
  end

  assign busyA = busy[chkA];
  assign busyB = busy[chkB];
  assign busyW = busy[chkW];

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode->execute register read, hazard stall, output reg.
// OPFETCH_BYPASS_EN: forward a same-cycle writeback into a stalled read.
module operand_fetch_stage #(
  parameter int DATA_W = kgp_risc_pkg::DATA_W,
  parameter int ADDR_W = kgp_risc_pkg::ADDR_W,
  parameter int CTRL_W = kgp_risc_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_we
);

  logic              busyA;
  logic              busyB;
  logic              busyW;
  logic              hitA;
  logic              hitB;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;

  assign rf_raddr1 = in_rs;
  assign rf_raddr2 = in_rt;

  reg_scoreboard #(
    .AW(ADDR_W)
  ) uSb (
    .clk    (clk),
    .rst    (rst),
    .setEn  (accept & in_rd_we),
    .setAddr(in_rd),
    .clrEn  (wb_we),
    .clrAddr(wb_addr),
    .chkA   (in_rs),
    .chkB   (in_rt),
    .chkW   (in_rd),
    .busyA  (busyA),
    .busyB  (busyB),
    .busyW  (busyW)
  );

`ifdef OPFETCH_BYPASS_EN
  assign hitA = wb_we & (wb_addr == in_rs);
  assign hitB = wb_we & (wb_addr == in_rt);
`else
  assign hitA = 1'b0;
  assign hitB = 1'b0;
`endif

  // A busy source is unblocked only by a forwarded writeback;
  // WAW always waits for the clear to land.
  assign hazard = in_valid &
                  ((busyA & ~hitA) |
                   (busyB & ~hitB) |
                   (in_rd_we & busyW));

  assign in_ready = ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  assign opA = hitA ? wb_data : rf_rdata1;
  assign opB = hitB ? wb_data : rf_rdata2;

  // Output register: load on accept, drop valid when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op_a  <= '0;
      out_op_b  <= '0;
      out_imm   <= '0;
      out_ctrl  <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op_a  <= opA;
      out_op_b  <= opB;
      out_imm   <= in_imm;
      out_ctrl  <= in_ctrl;
      out_rd    <= in_rd;
      out_rd_we <= in_rd_we;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed scenarios plus a random stream
// checked against an architectural register/pending-write model.
module tb_operand_fetch_stage;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_rd_we;
  logic [31:0] in_imm;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b, out_imm;
  logic [15:0] out_ctrl;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  logic [31:0] rf [32];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  operand_fetch_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rd_we(in_rd_we), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_imm(out_imm), .out_ctrl(out_ctrl),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, imm;
    logic [15:0] ctrl;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        q[$];
  bit          mBusy [32];
  int          total = 0;
  int          bad   = 0;
  int          nAcc  = 0;
  bit          lastAcc;
  bit          pWe = 0;
  logic [4:0]  pAddr;
  logic [31:0] pData;

  bit          sValid, sRdWe, sWbWe, sOutReady;
  logic [4:0]  sRs, sRt, sRd, sWbAddr;
  logic [31:0] sImm, sWbData;
  logic [15:0] sCtrl;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit blk(input logic [4:0] r);
    return mBusy[r] && !(BYP && sWbWe && sWbAddr == r);
  endfunction

  function automatic logic [31:0] fetch(input logic [4:0] r);
    if (BYP && sWbWe && sWbAddr == r) return sWbData;
    return rf[r];
  endfunction

  task automatic cycle();
    exp_t e;
    bit vNow, hz, rdy, acc;
    @(negedge clk);
    if (pWe) rf[pAddr] = pData;
    pWe = 0;
    in_valid  = sValid;
    in_rs     = sRs;
    in_rt     = sRt;
    in_rd     = sRd;
    in_rd_we  = sRdWe;
    in_imm    = sImm;
    in_ctrl   = sCtrl;
    wb_we     = sWbWe;
    wb_addr   = sWbAddr;
    wb_data   = sWbData;
    out_ready = sOutReady;
    #1;
    vNow = (q.size() != 0);
    chk("out_valid", out_valid, vNow);
    chk("raddr1", rf_raddr1, sRs);
    if (vNow && sOutReady) begin
      e = q.pop_front();
      chk("op_a", out_op_a, e.a);
      chk("op_b", out_op_b, e.b);
      chk("imm", out_imm, e.imm);
      chk("ctrl", out_ctrl, e.ctrl);
      chk("rd", out_rd, e.rd);
      chk("rd_we", out_rd_we, e.we);
    end
    hz  = sValid && (blk(sRs) || blk(sRt) || (sRdWe && mBusy[sRd]));
    rdy = !hz && (!vNow || sOutReady);
    chk("in_ready", in_ready, rdy);
    acc = sValid && rdy;
    if (acc) begin
      e.a = fetch(sRs);
      e.b = fetch(sRt);
      e.imm = sImm;
      e.ctrl = sCtrl;
      e.rd = sRd;
      e.we = sRdWe;
      q.push_back(e);
      nAcc++;
    end
    if (sWbWe) begin
      mBusy[sWbAddr] = 0;
      pWe = 1;
      pAddr = sWbAddr;
      pData = sWbData;
    end
    if (acc && sRdWe) mBusy[sRd] = 1;
    lastAcc = acc;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit we);
    sValid = 1; sRs = rs; sRt = rt; sRd = rd; sRdWe = we;
    sImm = $urandom; sCtrl = 16'($urandom);
  endtask

  task automatic wb(input bit en, input logic [4:0] a,
                    input logic [31:0] d);
    sWbWe = en; sWbAddr = a; sWbData = d;
  endtask

  logic [31:0] snapA, snapImm;
  int startAcc, cyc;
  logic [4:0] r;

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
      mBusy[i] = 0;
    end
    sValid = 0; sRs = 0; sRt = 0; sRd = 0; sRdWe = 0;
    sImm = 0; sCtrl = 0; sOutReady = 1;
    wb(0, 0, 0);
    in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_rd_we = 0;
    in_imm = 0; in_ctrl = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    out_ready = 1;
    rst = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_op_a", out_op_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Mid-stream reset with a held output and busy[5].
    sOutReady = 0;
    instr(1, 2, 5, 1);
    cycle();
    chk("t1_acc", lastAcc, 1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("t1_valid", out_valid, 0);
    chk("t1_op_a", out_op_a, 0);
    chk("t1_imm", out_imm, 0);
    chk("t1_rd_we", out_rd_we, 0);
    q.delete();
    for (int i = 0; i < 32; i++) mBusy[i] = 0;
    #1 rst = 0;
    sOutReady = 1;
    instr(5, 5, 5, 1);
    cycle();
    chk("t1_rdy", lastAcc, 1);
    sValid = 0;
    wb(1, 5, $urandom);
    cycle();
    wb(0, 0, 0);

    // RAW on r3: stall until writeback.
    instr(1, 2, 3, 1);
    cycle();
    chk("t2_acc1", lastAcc, 1);
    instr(3, 2, 9, 0);
    repeat (5) begin
      cycle();
      chk("t2_stall", lastAcc, 0);
    end
    wb(1, 3, 32'hDEAD_BEEF);
    cycle();
    chk("t2_wbcyc", lastAcc, BYP);
    wb(0, 0, 0);
    if (!BYP) begin
      cycle();
      chk("t2_late", lastAcc, 1);
    end
    sValid = 0;
    @(posedge clk);
    #1 chk("t2_op_a", out_op_a, 32'hDEAD_BEEF);
    cycle();

    // Back-pressure for 4 cycles, then one per cycle.
    instr(10, 11, 12, 0);
    sOutReady = 0;
    cycle();
    @(posedge clk);
    #1;
    snapA = out_op_a;
    snapImm = out_imm;
    instr(13, 14, 15, 0);
    repeat (4) begin
      cycle();
      chk("t3_rdy", in_ready, 0);
      chk("t3_hold_a", out_op_a, snapA);
      chk("t3_hold_imm", out_imm, snapImm);
    end
    sOutReady = 1;
    repeat (4) begin
      instr(5'($urandom_range(16, 20)), 21, 22, 0);
      cycle();
      chk("t3_flow", lastAcc, 1);
    end
    sValid = 0;
    cycle();

    // WAW on r7, then same-cycle set and clear.
    instr(1, 2, 7, 1);
    cycle();
    chk("t4_acc1", lastAcc, 1);
    instr(1, 2, 7, 1);
    repeat (3) begin
      cycle();
      chk("t4_stall", lastAcc, 0);
    end
    wb(1, 7, $urandom);
    cycle();
    chk("t4_wbcyc", lastAcc, 0);
    wb(1, 7, $urandom);
    cycle();
    chk("t4_acc2", lastAcc, 1);
    wb(0, 0, 0);
    instr(7, 1, 8, 0);
    cycle();
    chk("t4_setwins", lastAcc, 0);
    wb(1, 7, $urandom);
    sValid = 0;
    cycle();
    wb(0, 0, 0);
    cycle();

    // r0 is an ordinary register.
    wb(1, 0, 32'h1234);
    cycle();
    wb(0, 0, 0);
    instr(0, 0, 1, 0);
    cycle();
    chk("t5_acc", lastAcc, 1);
    sValid = 0;
    @(posedge clk);
    #1;
    chk("t5_op_a", out_op_a, 32'h1234);
    chk("t5_op_b", out_op_b, 32'h1234);
    cycle();

    // Random stream.
    startAcc = nAcc;
    cyc = 0;
    while (nAcc - startAcc < 1000 && cyc < 20000) begin
      instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      sValid = ($urandom_range(0, 3) != 0);
      sOutReady = ($urandom_range(0, 4) != 0);
      wb(0, 0, 0);
      if ($urandom_range(0, 2) == 0) begin
        r = 5'($urandom_range(0, 7));
        if (mBusy[r] || $urandom_range(0, 5) == 0) wb(1, r, $urandom);
      end
      cycle();
      cyc++;
    end
    chk("rand_done", (nAcc - startAcc >= 1000), 1);
    sValid = 0;
    sOutReady = 1;
    wb(0, 0, 0);
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
